data_cache_sa: RTL and testbench

//  Parametrised N-way set-associative write-back data cache array for the LSU/MEM stage.

---
 rtl/data_cache_sa_pkg.sv | 51 +++++
 rtl/data_cache_sa_dc_lru_set.sv | 35 +++
 rtl/data_cache_sa.sv | 208 ++++++++++++++++++++
 tb/tb_data_cache_sa.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_sa_pkg.sv
// Shared geometry, metadata layout and LRU helpers for the set-associative data cache.
package data_cache_sa_pkg;

   localparam int DC_NUM_SETS    = 64;
   localparam int DC_NUM_WAYS    = 2;
   localparam int DC_BLOCK_BYTES = 16;
   localparam int DC_ADDR_W      = 32;
   localparam int DC_LINE_W      = DC_BLOCK_BYTES * 8;
   // Widest tag any legal geometry can produce (>=4-byte lines, >=2 sets), so the
   // metadata port keeps one layout whatever the instance parameters are.
   localparam int DC_META_TAG_W  = DC_ADDR_W - 3;
   localparam int DC_MAX_WAYS    = 8;
   localparam int DC_AGE_W       = 3;

   typedef logic [DC_LINE_W-1:0] dc_line_t;

   typedef struct packed {
      logic                     valid;
      logic                     dirty;
      logic [DC_META_TAG_W-1:0] tag;
   } cache_metadata_t;

   // One age per way, 0 = MRU, nways-1 = LRU; slots at or above nways are inert.
   typedef logic [DC_MAX_WAYS-1:0][DC_AGE_W-1:0] lru_age_vec_t;

   // Make 'way' MRU; only ways younger than it age by one, so ages stay a permutation.
   function automatic lru_age_vec_t lru_touch(input lru_age_vec_t ages,
                                              input logic [DC_AGE_W-1:0] way,
                                              input int nways);
      lru_age_vec_t r;
      r = ages;
      for (int i = 0; i < DC_MAX_WAYS; i++) begin
         if (i < nways) begin
            if (DC_AGE_W'(i) == way)
               r[i] = '0;
            else if (ages[i] < ages[way])
               r[i] = ages[i] + DC_AGE_W'(1);
         end
      end
      return r;
   endfunction

   // Canonical post-reset order: way i has age i (way nways-1 is LRU).
   function automatic lru_age_vec_t lru_reset_ages();
      lru_age_vec_t r;
      for (int i = 0; i < DC_MAX_WAYS; i++)
         r[i] = DC_AGE_W'(i);
      return r;
   endfunction

endpackage

// File: rtl/data_cache_sa_dc_lru_set.sv
// True-LRU age state for one set: read touch first, then write touch, victim after the read touch.
module dc_lru_set
   import data_cache_sa_pkg::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int WAY_W    = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rd_touch_i,
   input  logic [WAY_W-1:0] rd_way_i,
   input  logic             wr_touch_i,
   input  logic [WAY_W-1:0] wr_way_i,
   output logic [WAY_W-1:0] victim_o
);

   lru_age_vec_t ages_q, ages_mid, ages_d;

   // Apply read touch, pick the LRU way from that, then apply the write touch.
   always_comb begin
      ages_mid = rd_touch_i ? lru_touch(ages_q, DC_AGE_W'(rd_way_i), NUM_WAYS) : ages_q;
      ages_d   = wr_touch_i ? lru_touch(ages_mid, DC_AGE_W'(wr_way_i), NUM_WAYS) : ages_mid;
      victim_o = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (ages_mid[w] == DC_AGE_W'(NUM_WAYS - 1))
            victim_o = WAY_W'(w);
   end

   // Age state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) ages_q <= lru_reset_ages();
      else       ages_q <= ages_d;
   end

endmodule

// File: rtl/data_cache_sa.sv
// N-way set-associative write-back data cache array with true-LRU fill allocation.
module data_cache_sa
   import data_cache_sa_pkg::*;
#(
   parameter int NUM_SETS    = DC_NUM_SETS,
   parameter int NUM_WAYS    = DC_NUM_WAYS,
   parameter int BLOCK_BYTES = DC_BLOCK_BYTES,
   parameter int ADDR_W      = DC_ADDR_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en,
   input  logic                     is_repair_i,
   input  logic                     is_repair_dirty_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [BLOCK_BYTES*8-1:0] wr_data_i,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   output logic                     rd_valid_o,
   output logic                     rd_hit_o,
   output logic [BLOCK_BYTES*8-1:0] rd_data_o,
   output cache_metadata_t          rd_tag_o,
   output logic                     wr_hit_o,
   output logic                     wb_evicted_en,
   output logic [ADDR_W-1:0]        wb_evicted_addr,
   output logic [BLOCK_BYTES*8-1:0] wb_evicted_block
);

   localparam int OFF_W  = $clog2(BLOCK_BYTES);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int LINE_W = BLOCK_BYTES * 8;

   logic              valid_q [NUM_SETS][NUM_WAYS];
   logic              dirty_q [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
   logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];

   logic [IDX_W-1:0]    rd_idx, wr_idx;
   logic [TAG_W-1:0]    rd_tag, wr_tag;
   logic [NUM_WAYS-1:0] rd_hit_vec, wr_hit_vec;
   logic [WAY_W-1:0]    rd_hit_way, wr_hit_way, free_way, victim_way, ent_way;
   logic                rd_hit, wr_hit, free_found, rd_touch, ent_we, ent_dirty_d, evict;
   logic [NUM_SETS-1:0][WAY_W-1:0] lru_victim;
   logic                unused_offset;

   assign rd_idx = rd_addr_i[OFF_W +: IDX_W];
   assign wr_idx = wr_addr_i[OFF_W +: IDX_W];
   assign rd_tag = rd_addr_i[ADDR_W-1 -: TAG_W];
   assign wr_tag = wr_addr_i[ADDR_W-1 -: TAG_W];
   assign unused_offset = ^{rd_addr_i[OFF_W-1:0], wr_addr_i[OFF_W-1:0]};

   // Tag compare on both ports plus first-invalid-way search in the write set.
   always_comb begin
      rd_hit_vec = '0;
      wr_hit_vec = '0;
      rd_hit_way = '0;
      wr_hit_way = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
            rd_hit_vec[w] = 1'b1;
            rd_hit_way    = WAY_W'(w);
         end
         if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
            wr_hit_vec[w] = 1'b1;
            wr_hit_way    = WAY_W'(w);
         end
         if (!valid_q[wr_idx][w] && !free_found) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
      end
      rd_hit = |rd_hit_vec;
      wr_hit = |wr_hit_vec;
   end

   assign rd_touch = rd_en && rd_hit;

   for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
      dc_lru_set #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_lru (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .rd_touch_i (rd_touch && rd_idx == IDX_W'(s)),
         .rd_way_i   (rd_hit_way),
         .wr_touch_i (ent_we && wr_idx == IDX_W'(s)),
         .wr_way_i   (ent_way),
         .victim_o   (lru_victim[s])
      );
   end

   // Write decision: store hits and fills pick a way; a non-duplicate fill may evict.
   always_comb begin
      victim_way  = free_found ? free_way : lru_victim[wr_idx];
      ent_we      = 1'b0;
      ent_way     = wr_hit_way;
      ent_dirty_d = 1'b1;
      evict       = 1'b0;
      if (wr_en && !is_repair_i && wr_hit) begin
         ent_we = 1'b1;
      end else if (wr_en && is_repair_i) begin
         ent_we = 1'b1;
         if (wr_hit) begin
            ent_dirty_d = dirty_q[wr_idx][wr_hit_way] | is_repair_dirty_i;
         end else begin
            ent_way     = victim_way;
            ent_dirty_d = is_repair_dirty_i;
            evict       = valid_q[wr_idx][victim_way] && dirty_q[wr_idx][victim_way];
         end
      end
   end

   logic                rd_valid_d, rd_hit_d, wr_hit_d, wb_en_d;
   logic [LINE_W-1:0]   rd_data_d, wb_block_d;
   cache_metadata_t     rd_tag_d;
   logic [ADDR_W-1:0]   wb_addr_d;
   logic                rd_valid_q, rd_hit_q, wr_hit_q, wb_en_q;
   logic [LINE_W-1:0]   rd_data_q, wb_block_q;
   cache_metadata_t     rd_tag_q;
   logic [ADDR_W-1:0]   wb_addr_q;

   // Next-cycle response values; reads see state before this cycle's write.
   always_comb begin
      rd_valid_d = rd_en;
      rd_hit_d   = rd_touch;
      rd_data_d  = '0;
      rd_tag_d   = '0;
      if (rd_touch) begin
         rd_data_d      = data_q[rd_idx][rd_hit_way];
         rd_tag_d.valid = 1'b1;
         rd_tag_d.dirty = dirty_q[rd_idx][rd_hit_way];
         rd_tag_d.tag   = DC_META_TAG_W'(tag_q[rd_idx][rd_hit_way]);
      end
      wr_hit_d   = wr_en && !is_repair_i && wr_hit;
      wb_en_d    = evict;
      wb_addr_d  = '0;
      wb_block_d = '0;
      if (evict) begin
         wb_addr_d  = {tag_q[wr_idx][victim_way], wr_idx, OFF_W'(0)};
         wb_block_d = data_q[wr_idx][victim_way];
      end
   end

   // Registered outputs, all cleared by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_tag_q   <= '0;
         wr_hit_q   <= 1'b0;
         wb_en_q    <= 1'b0;
         wb_addr_q  <= '0;
         wb_block_q <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_hit_q   <= rd_hit_d;
         rd_data_q  <= rd_data_d;
         rd_tag_q   <= rd_tag_d;
         wr_hit_q   <= wr_hit_d;
         wb_en_q    <= wb_en_d;
         wb_addr_q  <= wb_addr_d;
         wb_block_q <= wb_block_d;
      end
   end

   // Valid/dirty state: cleared on reset, updated by the chosen write way.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               dirty_q[s][w] <= 1'b0;
            end
      end else if (ent_we) begin
         valid_q[wr_idx][ent_way] <= 1'b1;
         dirty_q[wr_idx][ent_way] <= ent_dirty_d;
      end
   end

   // Tag/data flop arrays; contents are don't-care while the way is invalid.
   always_ff @(posedge clk_i) begin
      if (!rst_i && ent_we) begin
         tag_q[wr_idx][ent_way]  <= wr_tag;
         data_q[wr_idx][ent_way] <= wr_data_i;
      end
   end

   // A set never holds the same tag twice, so lookups match at most one way.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert ($onehot0(rd_hit_vec));
         assert ($onehot0(wr_hit_vec));
      end
   end

   assign rd_valid_o       = rd_valid_q;
   assign rd_hit_o         = rd_hit_q;
   assign rd_data_o        = rd_data_q;
   assign rd_tag_o         = rd_tag_q;
   assign wr_hit_o         = wr_hit_q;
   assign wb_evicted_en    = wb_en_q;
   assign wb_evicted_addr  = wb_addr_q;
   assign wb_evicted_block = wb_block_q;

endmodule

// File: tb/tb_data_cache_sa.sv
// Scoreboard bench for data_cache_sa (default geometry: 64 sets, 2 ways, 16-byte lines).
module tb_data_cache_sa;
   import data_cache_sa_pkg::*;

   logic clk_i, rst_i, wr_en, is_repair_i, is_repair_dirty_i, rd_en;
   logic [31:0] wr_addr_i, rd_addr_i, wb_evicted_addr;
   logic [127:0] wr_data_i, rd_data_o, wb_evicted_block;
   logic rd_valid_o, rd_hit_o, wr_hit_o, wb_evicted_en;
   cache_metadata_t rd_tag_o;

   data_cache_sa dut (
      .clk_i(clk_i), .rst_i(rst_i), .wr_en(wr_en), .is_repair_i(is_repair_i),
      .is_repair_dirty_i(is_repair_dirty_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
      .rd_en(rd_en), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o), .rd_hit_o(rd_hit_o),
      .rd_data_o(rd_data_o), .rd_tag_o(rd_tag_o), .wr_hit_o(wr_hit_o),
      .wb_evicted_en(wb_evicted_en), .wb_evicted_addr(wb_evicted_addr),
      .wb_evicted_block(wb_evicted_block));

   typedef struct packed {
      logic rst; logic re; logic [31:0] ra;
      logic we; logic rep; logic repd; logic [31:0] wa; logic [127:0] wd;
   } stim_t;

   typedef struct packed {
      logic rv; logic rh; logic [127:0] rd; cache_metadata_t rt;
      logic wh; logic we; logic [31:0] wa; logic [127:0] wb;
   } obs_t;

   int total = 0;
   int bad   = 0;
   obs_t exp_q[$];

   initial begin clk_i = 1'b0; forever #5 clk_i = ~clk_i; end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got=running required=done");
      $fatal(1);
   end

   // ---- stimulus / expectation constructors ----
   function automatic stim_t IDLE();
      stim_t s; s = '0; return s;
   endfunction
   function automatic stim_t RD(input logic [31:0] a);
      stim_t s; s = '0; s.re = 1'b1; s.ra = a; return s;
   endfunction
   function automatic stim_t FILL(input logic [31:0] a, input logic [127:0] d, input logic dirty);
      stim_t s; s = '0; s.we = 1'b1; s.rep = 1'b1; s.repd = dirty; s.wa = a; s.wd = d; return s;
   endfunction
   function automatic stim_t ST(input logic [31:0] a, input logic [127:0] d);
      stim_t s; s = '0; s.we = 1'b1; s.wa = a; s.wd = d; return s;
   endfunction
   function automatic obs_t NONE();
      obs_t e; e = '0; return e;
   endfunction
   function automatic obs_t MISS();
      obs_t e; e = '0; e.rv = 1'b1; return e;
   endfunction
   function automatic obs_t HIT(input logic [127:0] d, input logic dirty, input logic [21:0] tag);
      obs_t e; e = '0; e.rv = 1'b1; e.rh = 1'b1; e.rd = d;
      e.rt.valid = 1'b1; e.rt.dirty = dirty; e.rt.tag = DC_META_TAG_W'(tag); return e;
   endfunction
   function automatic obs_t WB(input logic [31:0] a, input logic [127:0] d);
      obs_t e; e = '0; e.we = 1'b1; e.wa = a; e.wb = d; return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.rv = rd_valid_o; o.rh = rd_hit_o; o.rd = rd_data_o; o.rt = rd_tag_o;
      o.wh = wr_hit_o; o.we = wb_evicted_en; o.wa = wb_evicted_addr; o.wb = wb_evicted_block;
      return o;
   endfunction

   // Drive one cycle of requests; outputs are stable 1 time unit after the edge.
   task automatic apply(input stim_t s);
      rst_i = s.rst; rd_en = s.re; rd_addr_i = s.ra; wr_en = s.we;
      is_repair_i = s.rep; is_repair_dirty_i = s.repd; wr_addr_i = s.wa; wr_data_i = s.wd;
      @(posedge clk_i); #1;
      rd_en = 1'b0; wr_en = 1'b0; is_repair_i = 1'b0; is_repair_dirty_i = 1'b0;
   endtask

   localparam logic [127:0] DA = {4{32'hAAAA_0001}};
   localparam logic [127:0] DB = {4{32'hBBBB_0002}};
   localparam logic [127:0] D0 = {4{32'hD000_0000}};
   localparam logic [127:0] D1 = {4{32'hD111_1111}};
   localparam logic [127:0] D2 = {4{32'hD222_2222}};
   localparam logic [127:0] D3 = {4{32'hD333_3333}};
   localparam logic [127:0] D4 = {4{32'hD444_4444}};
   localparam logic [127:0] D5 = {4{32'hD555_5555}};
   localparam logic [127:0] D6 = {4{32'hD666_6666}};

   task automatic test_reset();
      stim_t st[$]; obs_t ex[$]; obs_t got, e; stim_t s;
      s = FILL(32'h100, DA, 1'b1); s.re = 1'b1; s.ra = 32'h100; s.rst = 1'b1;
      st.push_back(s);                ex.push_back(NONE());
      st.push_back(s);                ex.push_back(NONE());
      st.push_back(RD(32'h100));      ex.push_back(MISS());
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL reset[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   task automatic test_fill_read();
      stim_t st[$]; obs_t ex[$]; obs_t got, e;
      st.push_back(FILL(32'h100, DA, 1'b0)); ex.push_back(NONE());
      st.push_back(RD(32'h10C));             ex.push_back(HIT(DA, 1'b0, 22'h0));
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL fill_read[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   task automatic test_store();
      stim_t st[$]; obs_t ex[$]; obs_t got, e, w;
      w = NONE(); w.wh = 1'b1;
      st.push_back(ST(32'h100, DB)); ex.push_back(w);
      st.push_back(RD(32'h100));     ex.push_back(HIT(DB, 1'b1, 22'h0));
      st.push_back(ST(32'h200, DA)); ex.push_back(NONE());
      st.push_back(RD(32'h200));     ex.push_back(MISS());
      st.push_back(RD(32'h104));     ex.push_back(HIT(DB, 1'b1, 22'h0));
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL store[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   // Set 0, tags 1..4 at 0x400/0x800/0xC00/0x1000.
   task automatic test_evict();
      stim_t st[$]; obs_t ex[$]; obs_t got, e;
      st.push_back(FILL(32'h400, D0, 1'b1));  ex.push_back(NONE());
      st.push_back(FILL(32'h800, D1, 1'b0));  ex.push_back(NONE());
      st.push_back(RD(32'h800));              ex.push_back(HIT(D1, 1'b0, 22'd2));
      st.push_back(FILL(32'hC00, D2, 1'b0));  ex.push_back(WB(32'h400, D0));
      st.push_back(FILL(32'h1000, D3, 1'b0)); ex.push_back(NONE());
      st.push_back(RD(32'h800));              ex.push_back(MISS());
      st.push_back(RD(32'hC00));              ex.push_back(HIT(D2, 1'b0, 22'd3));
      st.push_back(RD(32'h1000));             ex.push_back(HIT(D3, 1'b0, 22'd4));
      st.push_back(FILL(32'hC00, D4, 1'b1));  ex.push_back(NONE());
      st.push_back(RD(32'hC00));              ex.push_back(HIT(D4, 1'b1, 22'd3));
      st.push_back(FILL(32'h400, D0, 1'b0));  ex.push_back(NONE());
      st.push_back(FILL(32'h800, D1, 1'b0));  ex.push_back(WB(32'hC00, D4));
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL evict[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   task automatic test_same_cycle();
      stim_t st[$]; obs_t ex[$]; obs_t got, e, x; stim_t s;
      s = FILL(32'h1C50, D5, 1'b0); s.re = 1'b1; s.ra = 32'h1C50;
      st.push_back(s);                ex.push_back(MISS());
      st.push_back(RD(32'h1C58));     ex.push_back(HIT(D5, 1'b0, 22'd7));
      s = FILL(32'h2050, D6, 1'b0); s.re = 1'b1; s.ra = 32'h10C;
      st.push_back(s);                ex.push_back(HIT(DB, 1'b1, 22'h0));
      st.push_back(RD(32'h2050));     ex.push_back(HIT(D6, 1'b0, 22'd8));
      s = ST(32'h1C50, D4); s.re = 1'b1; s.ra = 32'h1C50;
      x = HIT(D5, 1'b0, 22'd7); x.wh = 1'b1;
      st.push_back(s);                ex.push_back(x);
      st.push_back(RD(32'h1C50));     ex.push_back(HIT(D4, 1'b1, 22'd7));
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL same_cycle[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   task automatic test_reset_mid();
      stim_t st[$]; obs_t ex[$]; obs_t got, e; stim_t s;
      st.push_back(FILL(32'h490, D0, 1'b1));  ex.push_back(NONE());
      st.push_back(FILL(32'h890, D1, 1'b1));  ex.push_back(NONE());
      s = FILL(32'hC90, D2, 1'b1); s.re = 1'b1; s.ra = 32'h490; s.rst = 1'b1;
      st.push_back(s);                        ex.push_back(NONE());
      st.push_back(RD(32'h490));              ex.push_back(MISS());
      st.push_back(RD(32'h890));              ex.push_back(MISS());
      st.push_back(RD(32'h100));              ex.push_back(MISS());
      st.push_back(FILL(32'hC90, D2, 1'b1));  ex.push_back(NONE());
      st.push_back(FILL(32'h1090, D3, 1'b0)); ex.push_back(NONE());
      st.push_back(FILL(32'h1490, D4, 1'b0)); ex.push_back(WB(32'hC90, D2));
      st.push_back(IDLE());                   ex.push_back(NONE());
      foreach (st[i]) begin
         exp_q.push_back(ex[i]); apply(st[i]); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL reset_mid[%0d] got=%h required=%h", i, got, e); end
      end
   endtask

   // ---- reference model: MRU-first order list per set ----
   logic         m_v [64][2];
   logic         m_d [64][2];
   logic [21:0]  m_t [64][2];
   logic [127:0] m_dat [64][2];
   int           m_ord [64][2];

   task automatic m_reset();
      for (int s = 0; s < 64; s++)
         for (int w = 0; w < 2; w++) begin
            m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; m_ord[s][w] = w;
         end
   endtask

   task automatic m_touch(input int s, input int w);
      int p;
      p = 0;
      for (int k = 0; k < 2; k++) if (m_ord[s][k] == w) p = k;
      for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
      m_ord[s][0] = w;
   endtask

   task automatic m_step(input stim_t s, output obs_t e);
      int ri, wi, rhw, whw, vw;
      logic rh, wh;
      e = '0; rh = 1'b0; wh = 1'b0; rhw = 0; whw = 0;
      ri = int'(s.ra[9:4]); wi = int'(s.wa[9:4]);
      for (int w = 0; w < 2; w++) begin
         if (m_v[ri][w] && m_t[ri][w] == s.ra[31:10]) begin rh = 1'b1; rhw = w; end
         if (m_v[wi][w] && m_t[wi][w] == s.wa[31:10]) begin wh = 1'b1; whw = w; end
      end
      if (s.re) begin
         e.rv = 1'b1;
         if (rh) begin
            e.rh = 1'b1; e.rd = m_dat[ri][rhw]; e.rt.valid = 1'b1;
            e.rt.dirty = m_d[ri][rhw]; e.rt.tag = DC_META_TAG_W'(m_t[ri][rhw]);
            m_touch(ri, rhw);
         end
      end
      if (s.we && !s.rep) begin
         if (wh) begin
            e.wh = 1'b1; m_dat[wi][whw] = s.wd; m_d[wi][whw] = 1'b1; m_touch(wi, whw);
         end
      end else if (s.we) begin
         if (wh) begin
            m_dat[wi][whw] = s.wd; m_d[wi][whw] = m_d[wi][whw] | s.repd; m_touch(wi, whw);
         end else begin
            vw = -1;
            for (int w = 0; w < 2; w++) if (!m_v[wi][w] && vw < 0) vw = w;
            if (vw < 0) vw = m_ord[wi][1];
            if (m_v[wi][vw] && m_d[wi][vw]) begin
               e.we = 1'b1; e.wa = {m_t[wi][vw], s.wa[9:4], 4'h0}; e.wb = m_dat[wi][vw];
            end
            m_v[wi][vw] = 1'b1; m_d[wi][vw] = s.repd; m_t[wi][vw] = s.wa[31:10];
            m_dat[wi][vw] = s.wd; m_touch(wi, vw);
         end
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = {22'($urandom_range(1, 3)), 6'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      return a;
   endfunction

   task automatic test_random();
      stim_t s; obs_t got, e;
      s = IDLE(); s.rst = 1'b1;
      m_reset(); m_step(s, e); e = '0;
      exp_q.push_back(e); apply(s); got = sample(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL random_reset got=%h required=%h", got, e); end
      for (int n = 0; n < 600; n++) begin
         s = IDLE();
         s.re = 1'($urandom_range(0, 1)); s.ra = rnd_addr();
         s.we = ($urandom_range(0, 9) < 6); s.rep = 1'($urandom_range(0, 1));
         s.repd = 1'($urandom_range(0, 1)); s.wa = rnd_addr();
         s.wd = {$urandom, $urandom, $urandom, $urandom};
         m_step(s, e);
         exp_q.push_back(e); apply(s); got = sample(); e = exp_q.pop_front(); total++;
         if (got !== e) begin bad++; $display("FAIL random[%0d] got=%h required=%h", n, got, e); end
      end
   endtask

   initial begin
      rst_i = 1'b1; rd_en = 1'b0; wr_en = 1'b0; is_repair_i = 1'b0; is_repair_dirty_i = 1'b0;
      rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
      @(negedge clk_i);
      test_reset();
      test_fill_read();
      test_store();
      test_evict();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
